// File: rtl/ctrl_pipe_pkg.sv
// Shared opcodes, bundle widths, field indices and control-bundle types for ctrl_pipe_unit.
package ctrl_pipe_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 3;

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;
    localparam int unsigned EX_W = ALUOP_W + 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

    // Field bit positions inside the flattened bundles
    localparam int unsigned WB_REGWRITE_BIT = 1;
    localparam int unsigned WB_MEMTOREG_BIT = 0;
    localparam int unsigned M_MEMWRITE_BIT  = 2;
    localparam int unsigned M_MEMREAD_BIT   = 1;
    localparam int unsigned M_BRANCH_BIT    = 0;
    localparam int unsigned EX_ALUSRC_BIT   = ALUOP_W + 1;
    localparam int unsigned EX_ALUOP_LSB    = 1;
    localparam int unsigned EX_REGDST_BIT   = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic mem_write;
        logic mem_read;
        logic branch;
    } m_ctrl_t;

    typedef struct packed {
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_dst;
    } ex_ctrl_t;

    typedef struct packed {
        wb_ctrl_t          wb;
        m_ctrl_t           m;
        ex_ctrl_t          ex;
        logic [REG_AW-1:0] rt;
    } id_ex_t;

    typedef struct packed {
        wb_ctrl_t wb;
        m_ctrl_t  m;
    } ex_mem_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> WB/M/EX bundles plus whether rt is a source operand.
module ctrl_decode
    import ctrl_pipe_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output wb_ctrl_t        wb_o,
    output m_ctrl_t         m_o,
    output ex_ctrl_t        ex_o,
    output logic            uses_rt_o
);

    // Unknown opcodes fall through to all-zero, i.e. a bubble
    always_comb begin
        wb_o      = wb_ctrl_t'(2'b00);
        m_o       = m_ctrl_t'(3'b000);
        ex_o      = ex_ctrl_t'(5'b00000);
        uses_rt_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                wb_o      = wb_ctrl_t'(2'b10);
                ex_o      = ex_ctrl_t'(5'b00101);
                uses_rt_o = 1'b1;
            end
            OP_LW: begin
                wb_o = wb_ctrl_t'(2'b11);
                m_o  = m_ctrl_t'(3'b010);
                ex_o = ex_ctrl_t'(5'b10000);
            end
            OP_SW: begin
                m_o       = m_ctrl_t'(3'b100);
                ex_o      = ex_ctrl_t'(5'b10000);
                uses_rt_o = 1'b1;
            end
            OP_BEQ: begin
                m_o       = m_ctrl_t'(3'b001);
                ex_o      = ex_ctrl_t'(5'b00010);
                uses_rt_o = 1'b1;
            end
            OP_ADDI: begin
                wb_o = wb_ctrl_t'(2'b10);
                ex_o = ex_ctrl_t'(5'b10110);
            end
            OP_ANDI: begin
                wb_o = wb_ctrl_t'(2'b10);
                ex_o = ex_ctrl_t'(5'b11000);
            end
            OP_ORI: begin
                wb_o = wb_ctrl_t'(2'b10);
                ex_o = ex_ctrl_t'(5'b11010);
            end
            OP_SLTI: begin
                wb_o = wb_ctrl_t'(2'b10);
                ex_o = ex_ctrl_t'(5'b11100);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decode in ID, carry bundles through ID/EX, EX/MEM, MEM/WB,
// load-use stall with bubble, taken-branch squash.
// Optional PERF_CNT_EN adds saturating stall/flush cycle counters.
module ctrl_pipe_unit
    import ctrl_pipe_pkg::*;
`ifdef PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid_i,
    input  logic [OP_W-1:0]   id_op_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              mem_br_taken_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [EX_W-1:0]   ex_ctrl_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [M_W-1:0]    mem_ctrl_o,
    output logic [WB_W-1:0]   wb_ctrl_o
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    wb_ctrl_t dec_wb;
    m_ctrl_t  dec_m;
    ex_ctrl_t dec_ex;
    logic     dec_uses_rt;

    id_ex_t   id_ex_q, id_ex_d;
    ex_mem_t  ex_mem_q, ex_mem_d;
    wb_ctrl_t mem_wb_q, mem_wb_d;

    logic     load_use;

    ctrl_decode u_decode (
        .op_i      (id_op_i),
        .wb_o      (dec_wb),
        .m_o       (dec_m),
        .ex_o      (dec_ex),
        .uses_rt_o (dec_uses_rt)
    );

    // Load-use hazard against the load in EX; flush overrides stall
    always_comb begin
        load_use = id_valid_i & id_ex_q.m.mem_read & (id_ex_q.rt != '0) &
                   ((id_ex_q.rt == id_rs_i) | ((id_ex_q.rt == id_rt_i) & dec_uses_rt));
        flush_o  = mem_br_taken_i;
        stall_o  = load_use & ~mem_br_taken_i;
    end

    // Next-state of the pipeline registers: bubbles on flush/stall/invalid
    always_comb begin
        id_ex_d  = '0;
        ex_mem_d = '0;
        mem_wb_d = ex_mem_q.wb;
        if (!(flush_o || stall_o || !id_valid_i)) begin
            id_ex_d.wb = dec_wb;
            id_ex_d.m  = dec_m;
            id_ex_d.ex = dec_ex;
            id_ex_d.rt = id_rt_i;
        end
        if (!flush_o) begin
            ex_mem_d.wb = id_ex_q.wb;
            ex_mem_d.m  = id_ex_q.m;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign ex_ctrl_o  = id_ex_q.ex;
    assign ex_rt_o    = id_ex_q.rt;
    assign mem_ctrl_o = ex_mem_q.m;
    assign wb_ctrl_o  = mem_wb_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
